hs_deserializer_2b8b: RTL and testbench

Receive-side counterpart of the 8-bit-to-2-bit HS serializer in the D-PHY data lane. The block takes two bit streams (odd bits and even bits of each byte), one dibit per RxDDRClk cycle, and hunts for the HS sync byte to find byte alignment. Once aligned, it reassembles bytes and presents them on a PPI-style byte interface with valid, active, sync and SoT-error indications. It sits between the HS-RX front end and the lane control/PPI logic.

---
 rtl/hs_deserializer_2b8b.sv | 125 ++++++++++++
 tb/tb_hs_deserializer_2b8b.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hs_deserializer_2b8b.sv
// HS receive deserializer: hunts for the sync byte on dibit granularity,
// then reassembles 2-bit-per-cycle data into bytes for the PPI side.
module hs_deserializer_2b8b #(
    parameter int          WIDTH        = 8,
    parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
    parameter int          HUNT_TIMEOUT = 32
) (
    input  logic             RxDDRClk,
    input  logic             RxRst,
    input  logic             deserializer_enable,
    input  logic             des_b1,
    input  logic             des_b2,
    output logic [WIDTH-1:0] RxDataHS,
    output logic             RxValidHS,
    output logic             RxActiveHS,
    output logic             RxSyncHS,
    output logic             ErrSotSyncHS
);
    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_DATA, S_ERR} state_e;

    localparam logic [7:0] TMO = 8'(HUNT_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       hunt_q, hunt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             sync_q, sync_d;
    logic             err_q, err_d;
    logic [7:0]       sr_shift;

    // Newest dibit enters at the top, so after four cycles byte bit 0 is at sr[0].
    assign sr_shift = {des_b1, des_b2, sr_q[7:2]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        phase_d = phase_q;
        hunt_d  = hunt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sync_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                sr_d    = '0;
                phase_d = '0;
                hunt_d  = '0;
                if (deserializer_enable) begin
                    state_d = S_HUNT;
                    sr_d    = {des_b1, des_b2, 6'b0};
                    hunt_d  = 8'd1;
                end
            end
            S_HUNT: begin
                if (!deserializer_enable) begin
                    state_d = S_IDLE;
                    sr_d    = '0;
                    hunt_d  = '0;
                end else begin
                    sr_d = sr_shift;
                    // A match on the timeout sample wins over the error.
                    if (sr_shift == SYNC_PATTERN) begin
                        state_d = S_DATA;
                        sync_d  = 1'b1;
                        phase_d = '0;
                    end else begin
                        hunt_d = hunt_q + 8'd1;
                        if (hunt_q + 8'd1 == TMO) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (!deserializer_enable) begin
                    state_d = S_IDLE;
                    sr_d    = '0;
                    phase_d = '0;
                end else begin
                    sr_d    = sr_shift;
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        data_d  = sr_shift;
                        valid_d = 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (!deserializer_enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge RxDDRClk) begin
        if (RxRst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            phase_q <= '0;
            hunt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            phase_q <= phase_d;
            hunt_q  <= hunt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

    assign RxDataHS     = data_q;
    assign RxValidHS    = valid_q;
    assign RxActiveHS   = (state_q == S_DATA);
    assign RxSyncHS     = sync_q;
    assign ErrSotSyncHS = err_q;
endmodule

// File: tb/tb_hs_deserializer_2b8b.sv
// Bench for hs_deserializer_2b8b: directed test-plan scenarios plus random
// traffic, every cycle compared against a dibit-history reference model.
module tb_hs_deserializer_2b8b;
    localparam int         TMO  = 32;
    localparam logic [7:0] SYNC = 8'hB8;

    logic       clk = 1'b0;
    logic       RxRst, deserializer_enable, des_b1, des_b2;
    logic [7:0] RxDataHS;
    logic       RxValidHS, RxActiveHS, RxSyncHS, ErrSotSyncHS;

    int nchk = 0;
    int nerr = 0;

    hs_deserializer_2b8b #(.WIDTH(8), .SYNC_PATTERN(SYNC), .HUNT_TIMEOUT(TMO)) dut (
        .RxDDRClk(clk), .RxRst(RxRst), .deserializer_enable(deserializer_enable),
        .des_b1(des_b1), .des_b2(des_b2), .RxDataHS(RxDataHS), .RxValidHS(RxValidHS),
        .RxActiveHS(RxActiveHS), .RxSyncHS(RxSyncHS), .ErrSotSyncHS(ErrSotSyncHS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: modes as plain ints, alignment found by looking at the
    // last four dibits received since enable rose, bytes collected in a list.
    int         m_mode = 0;  // 0 idle, 1 hunting, 2 aligned, 3 error
    int         m_nsamp = 0;
    logic [1:0] m_hist[$];
    logic [1:0] m_bytebuf[$];
    logic [7:0] e_data = 8'h00;
    logic       e_valid = 0, e_sync = 0, e_err = 0;

    function automatic logic [7:0] last4_value();
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            int idx = m_hist.size() - 4 + i;
            if (idx >= 0) v += int'(m_hist[idx]) * (4 ** i);
        end
        return 8'(v);
    endfunction

    function automatic logic [7:0] buf_value();
        int v = 0;
        for (int i = 0; i < 4; i++) v += int'(m_bytebuf[i]) * (4 ** i);
        return 8'(v);
    endfunction

    task automatic model(input logic r, input logic e, input logic [1:0] d);
        e_valid = 0; e_sync = 0; e_err = 0;
        if (r) begin
            m_mode = 0; e_data = 8'h00;
        end else begin
            case (m_mode)
                0: if (e) begin
                    m_hist = {}; m_hist.push_back(d); m_nsamp = 1; m_mode = 1;
                end
                1: if (!e) m_mode = 0;
                   else begin
                       m_hist.push_back(d); m_nsamp++;
                       if (last4_value() == SYNC) begin
                           e_sync = 1; m_mode = 2; m_bytebuf = {};
                       end else if (m_nsamp == TMO) begin
                           e_err = 1; m_mode = 3;
                       end
                   end
                2: if (!e) m_mode = 0;
                   else begin
                       m_bytebuf.push_back(d);
                       if (m_bytebuf.size() == 4) begin
                           e_data = buf_value(); e_valid = 1; m_bytebuf = {};
                       end
                   end
                default: if (!e) m_mode = 0;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] d);
        RxRst = r; deserializer_enable = e; {des_b1, des_b2} = d;
        @(posedge clk);
        model(r, e, d);
        #1;
        chk("data",   32'(RxDataHS),     32'(e_data));
        chk("valid",  32'(RxValidHS),    32'(e_valid));
        chk("active", 32'(RxActiveHS),   32'(m_mode == 2));
        chk("sync",   32'(RxSyncHS),     32'(e_sync));
        chk("err",    32'(ErrSotSyncHS), 32'(e_err));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) step(0, 1, b[2*k +: 2]);
    endtask

    logic [1:0] pend[$];
    int         lowcnt = 0;

    initial begin
        RxRst = 1; deserializer_enable = 0; des_b1 = 0; des_b2 = 0;
        #1;
        step(1, 0, 0); step(1, 0, 0);
        chk("rst_data", 32'(RxDataHS), 0);
        chk("rst_act",  32'(RxActiveHS), 0);

        // Basic byte
        send_byte(SYNC);
        chk("basic_sync", 32'(RxSyncHS), 1);
        send_byte(8'hAA);
        chk("basic_valid", 32'(RxValidHS), 1);
        chk("basic_data",  32'(RxDataHS), 32'h AA);
        step(0, 0, 0);

        // Misaligned start
        step(0, 1, 2'b11); step(0, 1, 2'b01); step(0, 1, 2'b00);
        send_byte(SYNC);
        chk("mis_sync", 32'(RxSyncHS), 1);
        send_byte(8'h55); chk("mis_55", 32'(RxDataHS), 32'h55);
        send_byte(8'h0F); chk("mis_0F", 32'(RxDataHS), 32'h0F);
        send_byte(8'hF0); chk("mis_F0", 32'(RxDataHS), 32'hF0);
        chk("mis_v", 32'(RxValidHS), 1);
        step(0, 0, 0);

        // Timeout
        for (int i = 1; i <= 40; i++) begin
            step(0, 1, 2'b11);
            chk("tmo_err", 32'(ErrSotSyncHS), 32'(i == TMO));
        end
        step(0, 0, 0);
        chk("tmo_idle", 32'(RxActiveHS), 0);
        send_byte(SYNC); chk("tmo_resync", 32'(RxSyncHS), 1);
        send_byte(8'h5A); chk("tmo_5A", 32'(RxDataHS), 32'h5A);

        // Enable drop mid-byte
        step(0, 0, 0);
        send_byte(SYNC); send_byte(8'hC3);
        chk("drop_C3", 32'(RxDataHS), 32'hC3);
        step(0, 1, 2'b00); step(0, 1, 2'b11);
        step(0, 0, 2'b11);
        chk("drop_act", 32'(RxActiveHS), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Enable drop on phase-3 edge
        send_byte(SYNC); send_byte(8'h12);
        step(0, 1, 2'b01); step(0, 1, 2'b10); step(0, 1, 2'b11);
        step(0, 0, 2'b10);
        chk("p3_novalid", 32'(RxValidHS), 0);
        chk("p3_hold",    32'(RxDataHS), 32'h12);

        // Reset mid-byte (during phase 2)
        send_byte(SYNC);
        step(0, 1, 2'b01); step(0, 1, 2'b10);
        step(1, 1, 2'b11);
        chk("rst_mid_data", 32'(RxDataHS), 0);
        chk("rst_mid_act",  32'(RxActiveHS), 0);
        send_byte(SYNC); send_byte(8'h81);
        chk("rst_81", 32'(RxDataHS), 32'h81);
        step(0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, e;
            logic [7:0] b;
            r = ($urandom_range(0, 299) == 0);
            if (lowcnt > 0) begin e = 0; lowcnt--; end
            else if ($urandom_range(0, 79) == 0) begin e = 0; lowcnt = $urandom_range(0, 3); end
            else e = 1;
            if (pend.size() == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    b = SYNC;
                    2:       b = 8'h00;
                    default: b = 8'($urandom);
                endcase
                if ($urandom_range(0, 7) == 0) pend.push_back(2'($urandom));
                for (int k = 0; k < 4; k++) pend.push_back(b[2*k +: 2]);
            end
            step(r, e, pend.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
